// File: rtl/network_sequencer_pkg.sv
// Shared types and constants for the network sequencer.
// Imported by the sequencer and by its shift-register neighbours.
package network_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_FEED = 2'b10;

endpackage

// File: rtl/network_sequencer.sv
// Sequences load, per-layer compute/feed and output drain
// for a four-neuron network built around a shift register.
module network_sequencer
  import network_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int NEURON_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] selector,
  output logic [1:0] selector_output,
  output logic [1:0] layer_idx,
  output logic       neuron_en,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAT_LAST   = 4'(NEURON_LATENCY - 1);
  localparam logic [1:0] LAYER_LAST = 2'(NUM_LAYERS - 1);

  state_t     state;
  logic [1:0] load_cnt;
  logic [3:0] lat_cnt;
  logic [1:0] drain_cnt;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign neuron_en = (state == COMPUTE);
  assign done      = (state == DONE);

  // Drain taps walk from neuron 3 down to neuron 0.
  assign selector_output =
    (state == DRAIN) ? ~drain_cnt : 2'b00;

  // Load select follows in_valid only while loading.
  always_comb begin
    selector = SEL_HOLD;
    unique case (1'b1)
      (state == LOAD): selector = in_valid ? SEL_LOAD : SEL_HOLD;
      (state == FEED): selector = SEL_FEED;
      default:         selector = SEL_HOLD;
    endcase
  end

  // Main FSM; out_valid/out_idx lag the tap by one cycle
  // to line up with the registered network outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      load_cnt  <= '0;
      lat_cnt   <= '0;
      drain_cnt <= '0;
      layer_idx <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      out_valid <= (state == DRAIN);
      out_idx   <= selector_output;
      unique case (state)
        IDLE: begin
          load_cnt  <= '0;
          lat_cnt   <= '0;
          drain_cnt <= '0;
          layer_idx <= '0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            load_cnt <= load_cnt + 2'd1;
            if (load_cnt == 2'd3) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= FEED;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        FEED: begin
          if (layer_idx < LAYER_LAST) begin
            layer_idx <= layer_idx + 2'd1;
            state     <= COMPUTE;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd3) state <= DONE;
        end
        DONE: begin
          layer_idx <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: timeline, gapped
// load, drain data, mid-run reset, 1-layer build, held start.
module tb_network_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       in_valid;
  logic [7:0] data_in;
  logic       in_ready;
  logic [1:0] selector;
  logic [1:0] selector_output;
  logic [1:0] layer_idx;
  logic       neuron_en;
  logic       out_valid;
  logic [1:0] out_idx;
  logic       busy;
  logic       done;

  logic       start1;
  logic       in_valid1;
  logic       s_in_ready;
  logic [1:0] s_selector;
  logic [1:0] s_selector_output;
  logic [1:0] s_layer_idx;
  logic       s_neuron_en;
  logic       s_out_valid;
  logic [1:0] s_out_idx;
  logic       s_busy;
  logic       s_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  nmodel [4];
  logic [7:0]  net_out;
  logic [31:0] sr;
  logic        sr_clr;

  always #5 clk = ~clk;

  network_sequencer dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .selector       (selector),
    .selector_output(selector_output),
    .layer_idx      (layer_idx),
    .neuron_en      (neuron_en),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .busy           (busy),
    .done           (done)
  );

  network_sequencer #(
    .NUM_LAYERS    (1),
    .NEURON_LATENCY(1)
  ) dut1 (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start1),
    .in_valid       (in_valid1),
    .in_ready       (s_in_ready),
    .selector       (s_selector),
    .selector_output(s_selector_output),
    .layer_idx      (s_layer_idx),
    .neuron_en      (s_neuron_en),
    .out_valid      (s_out_valid),
    .out_idx        (s_out_idx),
    .busy           (s_busy),
    .done           (s_done)
  );

  // Registered output tap of a neuron-model shift register.
  always @(posedge clk) net_out <= nmodel[selector_output];

  // Input shift register model: captures data_in on selector=00.
  always @(posedge clk) begin
    if (sr_clr) sr <= '0;
    else if (selector == 2'b00) sr <= {sr[23:0], data_in};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"}, 32'(selector), 32'h1);
    chk({tag, "_selout"}, 32'(selector_output), 32'h0);
    chk({tag, "_layer"}, 32'(layer_idx), 32'h0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'h0);
    chk({tag, "_nen"}, 32'(neuron_en), 32'h0);
    chk({tag, "_ov"}, 32'(out_valid), 32'h0);
    chk({tag, "_oidx"}, 32'(out_idx), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Full default-parameter inference, checked cycle by cycle.
  task automatic run_default(input string tag);
    logic [31:0] exp_ne, exp_fd, exp_dn, exp_ov, exp_ld;
    exp_ne = 32'h0000_1B60;
    exp_fd = 32'h0000_2480;
    exp_dn = 32'h0004_0000;
    exp_ov = 32'h0007_8000;
    exp_ld = 32'h0000_001E;
    for (int t = 0; t <= 20; t++) begin
      start    = (t == 0);
      in_valid = (t >= 1 && t <= 4);
      data_in  = 8'(t * 16 + t);
      #1;
      chk($sformatf("%s_nen_t%0d", tag, t), 32'(neuron_en),
          32'(exp_ne[t]));
      chk($sformatf("%s_feed_t%0d", tag, t),
          32'(selector == 2'b10), 32'(exp_fd[t]));
      chk($sformatf("%s_load_t%0d", tag, t),
          32'(selector == 2'b00), 32'(exp_ld[t]));
      chk($sformatf("%s_done_t%0d", tag, t), 32'(done),
          32'(exp_dn[t]));
      chk($sformatf("%s_ov_t%0d", tag, t), 32'(out_valid),
          32'(exp_ov[t]));
      if (t == 5 || t == 8 || t == 11)
        chk($sformatf("%s_layer_t%0d", tag, t), 32'(layer_idx),
            32'((t - 5) / 3));
      if (t >= 14 && t <= 17)
        chk($sformatf("%s_tap_t%0d", tag, t),
            32'(selector_output), 32'(17 - t));
      if (t >= 15 && t <= 18) begin
        chk($sformatf("%s_oidx_t%0d", tag, t), 32'(out_idx),
            32'(18 - t));
        chk($sformatf("%s_nout_t%0d", tag, t), 32'(net_out),
            32'(nmodel[18 - t]));
      end
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int first;
    int second;
    int seen;
    logic found;

    for (int i = 0; i < 4; i++) nmodel[i] = 8'(8'hA0 + i * 8'h11);
    rstn      = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    start1    = 1'b0;
    in_valid1 = 1'b0;
    sr_clr    = 1'b1;
    #1;
    chk_reset_vals("rst0");
    tick();
    rstn = 1'b0;
    tick();

    run_default("run1");

    // Gapped load: words at t1, t4, t7, t10.
    sr_clr = 1'b1;
    tick();
    sr_clr = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      start    = (t == 0);
      in_valid = (t == 1 || t == 4 || t == 7 || t == 10 || t >= 11);
      unique case (t)
        1:       data_in = 8'h11;
        4:       data_in = 8'h22;
        7:       data_in = 8'h33;
        10:      data_in = 8'h44;
        default: data_in = 8'h55;
      endcase
      #1;
      if (selector == 2'b00) cnt++;
      if (t == 10) chk("gap_nen_t10", 32'(neuron_en), 32'h0);
      if (t == 11) chk("gap_nen_t11", 32'(neuron_en), 32'h1);
      if (done) found = 1'b1;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("gap_loads", 32'(cnt), 32'd4);
    chk("gap_done_seen", 32'(found), 32'h1);
    chk("gap_sr", sr, 32'h1122_3344);

    // Reset in the second COMPUTE (t8).
    for (int t = 0; t < 8; t++) begin
      start    = (t == 0);
      in_valid = (t >= 1 && t <= 4);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("mid_nen_pre", 32'(neuron_en), 32'h1);
    chk("mid_layer_pre", 32'(layer_idx), 32'h1);
    rstn = 1'b1;
    #1;
    chk_reset_vals("mid");
    tick();
    rstn = 1'b0;
    tick();
    run_default("run2");

    // Single-layer, latency-1 instance.
    cnt = -1;
    for (int t = 0; t <= 30; t++) begin
      start1    = (t == 0);
      in_valid1 = 1'b1;
      #1;
      if (s_done && cnt < 0) cnt = t;
      if (s_selector == 2'b10) chk("one_feed_layer",
                                   32'(s_layer_idx), 32'h0);
      tick();
    end
    start1    = 1'b0;
    in_valid1 = 1'b0;
    chk("one_done_lat", 32'(cnt), 32'd11);

    // Start held high: done pulses 19 cycles apart.
    first  = -1;
    second = -1;
    seen   = 0;
    for (int t = 0; t < 60; t++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      #1;
      if (done) begin
        seen++;
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("hold_first", 32'(first), 32'd18);
    chk("hold_period", 32'(second - first), 32'd19);
    chk("hold_count", 32'(seen), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
